// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory arbiter
package dmem_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/dmem_req_decode.sv
// rtl/dmem_req_decode.sv - funct3 and alignment decode of the arbitrated request
module dmem_req_decode
    import dmem_pkg::*;
(
    input  logic       i_we,
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    output logic [1:0] o_load_size,
    output logic       o_load_signed,
    output logic       o_legal
);

    logic w_f3_ok;
    logic w_aligned;

    always_comb begin
        o_load_size   = LS_WORD;
        o_load_signed = 1'b0;
        w_f3_ok       = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_load_size   = LS_BYTE;
                o_load_signed = ~i_we;
                w_f3_ok       = 1'b1;
            end
            F3_LH: begin
                o_load_size   = LS_HALF;
                o_load_signed = ~i_we;
                w_f3_ok       = 1'b1;
            end
            F3_LW: begin
                o_load_size = LS_WORD;
                w_f3_ok     = 1'b1;
            end
            // unsigned variants exist only for loads
            F3_LBU: begin
                o_load_size = LS_BYTE;
                w_f3_ok     = ~i_we;
            end
            F3_LHU: begin
                o_load_size = LS_HALF;
                w_f3_ok     = ~i_we;
            end
            default: w_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_aligned = 1'b1;
        case (o_load_size)
            LS_HALF: w_aligned = ~i_addr_lo[0];
            LS_WORD: w_aligned = (i_addr_lo == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign o_legal = w_f3_ok & w_aligned;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with starvation guard
// and in-order routing of read returns to the issuing port
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [2:0]            funct3_0,
    input  logic [2:0]            funct3_1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  err0,
    output logic                  err1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata0,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  stall0,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    output logic [1:0]            LoadSize,
    output logic                  LoadSigned,
    input  logic [DATA_W-1:0]     rd
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_inf_valid [READ_LAT];
    port_id_t              r_inf_owner [READ_LAT];
    logic                  r_err0;
    logic                  r_err1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic                  w_win1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any;
    logic                  w_issue;
    port_id_t              w_winner;
    logic                  w_we;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic [2:0]            w_funct3;
    logic [1:0]            w_load_size;
    logic                  w_load_signed;
    logic                  w_legal;
    logic                  w_tail_valid;
    port_id_t              w_tail_owner;

    // Port 0 has priority unless port 1 has waited STARVE_MAX cycles
    assign w_win1   = req1 & (~req0 | (r_starve_cnt == STARVE_LIM));
    assign w_gnt0   = rst_n & req0 & ~w_win1;
    assign w_gnt1   = rst_n & w_win1;
    assign w_any    = w_gnt0 | w_gnt1;
    assign w_winner = w_win1 ? PORT1 : PORT0;

    assign w_we     = w_win1 ? we1      : we0;
    assign w_addr   = w_win1 ? addr1    : addr0;
    assign w_wdata  = w_win1 ? wdata1   : wdata0;
    assign w_funct3 = w_win1 ? funct3_1 : funct3_0;

    dmem_req_decode u_decode (
        .i_we          (w_we),
        .i_funct3      (w_funct3),
        .i_addr_lo     (w_addr[1:0]),
        .o_load_size   (w_load_size),
        .o_load_signed (w_load_signed),
        .o_legal       (w_legal)
    );

    // Illegal requests are consumed by the grant but never reach memory
    assign w_issue    = w_any & w_legal;
    assign MemRead    = w_issue & ~w_we;
    assign MemWrite   = w_issue & w_we;
    assign a          = w_issue ? w_addr        : '0;
    assign wd         = w_issue ? w_wdata       : '0;
    assign Funct3     = w_issue ? w_funct3      : 3'b000;
    assign LoadSize   = w_issue ? w_load_size   : LS_WORD;
    assign LoadSigned = w_issue & w_load_signed;

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign stall0 = req0 & ~w_gnt0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!req1 || w_gnt1) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_inf_valid[i] <= 1'b0;
                r_inf_owner[i] <= PORT0;
            end
        end else begin
            r_inf_valid[0] <= MemRead;
            r_inf_owner[0] <= w_winner;
            for (int i = 1; i < READ_LAT; i++) begin
                r_inf_valid[i] <= r_inf_valid[i-1];
                r_inf_owner[i] <= r_inf_owner[i-1];
            end
        end
    end

    assign w_tail_valid = r_inf_valid[READ_LAT-1];
    assign w_tail_owner = r_inf_owner[READ_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_err0    <= w_gnt0 & ~w_legal;
            r_err1    <= w_gnt1 & ~w_legal;
            r_rvalid0 <= w_tail_valid & (w_tail_owner == PORT0);
            r_rvalid1 <= w_tail_valid & (w_tail_owner == PORT1);
            if (w_tail_valid) begin
                if (w_tail_owner == PORT1) begin
                    r_rdata1 <= rd;
                end else begin
                    r_rdata0 <= rd;
                end
            end
        end
    end

    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int READ_LAT   = 2;
    localparam int STARVE_MAX = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req0, req1, we0, we1;
    logic [DM_ADDRESS-1:0] addr0, addr1;
    logic [DATA_W-1:0]     wdata0, wdata1;
    logic [2:0]            funct3_0, funct3_1;
    logic                  gnt0, gnt1, err0, err1, rvalid0, rvalid1, stall0;
    logic [DATA_W-1:0]     rdata0, rdata1;
    logic                  MemRead, MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [1:0]            LoadSize;
    logic                  LoadSigned;
    logic [DATA_W-1:0]     rd;

    dmem_arbiter #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W),
        .READ_LAT   (READ_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .funct3_0   (funct3_0),
        .funct3_1   (funct3_1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .err0       (err0),
        .err1       (err1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .stall0     (stall0),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .LoadSize   (LoadSize),
        .LoadSigned (LoadSigned),
        .rd         (rd)
    );

    always #5 clk = ~clk;

    // Memory model: interprets the DUT's memory-side controls, READ_LAT = 2 pipeline
    logic [31:0] mem_model [128];
    logic [31:0] mp0 = '0;
    logic [31:0] mp1 = '0;

    function automatic logic [31:0] mem_extract(logic [31:0] w, logic [1:0] lane,
                                                logic [1:0] size, logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = w[16*lane[1] +: 16];
        case (size)
            2'b10:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (MemWrite) begin
            case (Funct3)
                3'd0:    mem_model[a[8:2]][8*a[1:0] +: 8]  <= wd[7:0];
                3'd1:    mem_model[a[8:2]][16*a[1] +: 16] <= wd[15:0];
                default: mem_model[a[8:2]] <= wd;
            endcase
        end
        if (MemRead) mp0 <= mem_extract(mem_model[a[8:2]], a[1:0], LoadSize, LoadSigned);
        mp1 <= mp0;
    end
    assign rd = mp1;

    // Reference model state
    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } pend_t;

    pend_t       pend [$];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd0, exp_rd1;
    int          starve;
    int          cyc;
    bit          exp_err0, exp_err1;
    logic        last_gnt1;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int acc_bytes(logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(bit we, logic [2:0] f3, int addr);
        bit ok;
        ok = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return ok && (addr % acc_bytes(f3) == 0);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, int addr, logic [2:0] f3);
        longint unsigned raw;
        int n;
        n   = acc_bytes(f3);
        raw = w;
        raw = (raw >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
        if (f3 < 3'd4 && n < 4 && raw >= (64'd1 << (8 * n - 1))) raw = raw - (64'd1 << (8 * n));
        return raw[31:0];
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] old, int addr, logic [2:0] f3,
                                              logic [31:0] d);
        longint unsigned m, o, dd;
        int sh;
        sh = 8 * (addr % 4);
        m  = ((64'd1 << (8 * acc_bytes(f3))) - 1) << sh;
        o  = old;
        dd = d;
        o  = (o & ~m) | ((dd << sh) & m);
        return o[31:0];
    endfunction

    function automatic logic [1:0] exp_ls(int n);
        return (n == 4) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
    endfunction

    task automatic tick();
        bit w1, g0, g1, we, legal, rv0, rv1;
        int ad;
        logic [2:0]  f3;
        logic [31:0] wdat;
        pend_t p;
        @(negedge clk);
        w1    = req1 && (!req0 || starve == STARVE_MAX);
        g1    = w1;
        g0    = req0 && !w1;
        we    = w1 ? we1 : we0;
        f3    = w1 ? funct3_1 : funct3_0;
        ad    = int'(w1 ? addr1 : addr0);
        wdat  = w1 ? wdata1 : wdata0;
        legal = (g0 || g1) && ref_legal(we, f3, ad);
        last_gnt1 = gnt1;
        check("gnt0", gnt0, g0);
        check("gnt1", gnt1, g1);
        check("stall0", stall0, req0 && !g0);
        check("MemRead", MemRead, legal && !we);
        check("MemWrite", MemWrite, legal && we);
        if (legal) begin
            check("a", a, ad);
            check("Funct3", Funct3, f3);
            if (we) begin
                check("wd", wd, wdat);
                ref_mem[ad / 4] = ref_store(ref_mem[ad / 4], ad, f3, wdat);
            end else begin
                check("LoadSize", LoadSize, exp_ls(acc_bytes(f3)));
                check("LoadSigned", LoadSigned, f3 == 3'd0 || f3 == 3'd1);
                p.port = w1;
                p.data = ref_load(ref_mem[ad / 4], ad, f3);
                p.due  = cyc + 1 + READ_LAT;
                pend.push_back(p);
            end
        end else if (!(g0 || g1)) begin
            check("idle_a", a, 0);
            check("idle_wd", wd, 0);
            check("idle_Funct3", Funct3, 0);
            check("idle_LoadSize", LoadSize, 0);
            check("idle_LoadSigned", LoadSigned, 0);
        end
        exp_err0 = g0 && !legal;
        exp_err1 = g1 && !legal;
        if (req1 && !g1) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
        else starve = 0;
        @(posedge clk);
        #1;
        cyc++;
        rv0 = 0;
        rv1 = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (p.port) begin rv1 = 1; exp_rd1 = p.data; end
            else begin rv0 = 1; exp_rd0 = p.data; end
        end
        check("err0", err0, exp_err0);
        check("err1", err1, exp_err1);
        check("rvalid0", rvalid0, rv0);
        check("rvalid1", rvalid1, rv1);
        check("rdata0", rdata0, exp_rd0);
        check("rdata1", rdata1, exp_rd1);
    endtask

    task automatic reset_regs_zero(input string tag);
        check({tag, "_err0"}, err0, 0);
        check({tag, "_err1"}, err1, 0);
        check({tag, "_rvalid0"}, rvalid0, 0);
        check({tag, "_rvalid1"}, rvalid1, 0);
        check({tag, "_rdata0"}, rdata0, 0);
        check({tag, "_rdata1"}, rdata1, 0);
    endtask

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        #1;
        reset_regs_zero("rst_async");
        repeat (ncyc) begin
            @(negedge clk);
            req0 = 1'b1; we0 = 1'b0; funct3_0 = 3'd2; addr0 = '0;
            req1 = 1'b1; we1 = 1'b1; funct3_1 = 3'd2; addr1 = 9'h004;
            #1;
            check("rst_gnt0", gnt0, 0);
            check("rst_gnt1", gnt1, 0);
            check("rst_MemRead", MemRead, 0);
            check("rst_MemWrite", MemWrite, 0);
            check("rst_stall0", stall0, 1);
            reset_regs_zero("rst_hold");
        end
        req0 = 1'b0;
        req1 = 1'b0;
        pend.delete();
        starve  = 0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input int port, input bit we, input logic [2:0] f3, input int ad,
                         input logic [31:0] d);
        req0 = (port == 0);
        req1 = (port == 1);
        if (port == 0) begin
            we0 = we; funct3_0 = f3; addr0 = ad[DM_ADDRESS-1:0]; wdata0 = d;
        end else begin
            we1 = we; funct3_1 = f3; addr1 = ad[DM_ADDRESS-1:0]; wdata1 = d;
        end
    endtask

    task automatic idle();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic load_check(input int port, input logic [2:0] f3, input int ad,
                              input logic [31:0] exp, input string tag);
        drive(port, 1'b0, f3, ad, '0);
        tick();
        idle();
        tick();
        tick();
        check(tag, (port == 1) ? rdata1 : rdata0, exp);
    endtask

    function automatic logic [2:0] rand_f3();
        if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
        return 3'($urandom_range(0, 2));
    endfunction

    initial begin
        int n1;
        int ad;
        rst_n = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; funct3_0 = '0; funct3_1 = '0;
        cyc = 0; starve = 0; exp_rd0 = '0; exp_rd1 = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        #2;
        apply_reset(2);

        for (int w = 0; w < 16; w++) begin
            drive(w % 2, 1'b1, 3'd2, w * 4, $urandom);
            tick();
        end
        idle();
        tick();

        drive(0, 1'b1, 3'd2, 'h10, 32'hDEADBEEF);
        tick();
        load_check(0, 3'd2, 'h10, 32'hDEADBEEF, "lw_deadbeef");
        drive(0, 1'b1, 3'd2, 'h10, 32'h000000F0);
        tick();
        load_check(0, 3'd0, 'h10, 32'hFFFFFFF0, "lb_signed");
        load_check(0, 3'd4, 'h10, 32'h000000F0, "lbu_unsigned");
        drive(0, 1'b1, 3'd2, 'h10, 32'h00008001);
        tick();
        load_check(0, 3'd1, 'h10, 32'hFFFF8001, "lh_signed");

        idle();
        tick();
        req0 = 1'b1; we0 = 1'b0; funct3_0 = 3'd2; addr0 = 9'h000;
        req1 = 1'b1; we1 = 1'b0; funct3_1 = 3'd2; addr1 = 9'h004;
        n1 = 0;
        repeat (3 * (STARVE_MAX + 1)) begin
            tick();
            n1 += int'(last_gnt1);
        end
        check("starve_grant_count", n1, 3);

        idle();
        tick();
        tick();
        tick();
        drive(1, 1'b0, 3'd1, 'h13, '0);
        tick();
        check("lh_misaligned_err1", err1, 1);
        idle();
        tick();
        check("err1_one_cycle", err1, 0);
        drive(1, 1'b0, 3'd3, 'h10, '0);
        tick();
        check("f3_011_err1", err1, 1);
        idle();
        tick();
        tick();

        drive(0, 1'b0, 3'd2, 'h000, '0);
        tick();
        drive(1, 1'b0, 3'd2, 'h004, '0);
        tick();
        idle();
        tick();
        tick();
        tick();

        drive(0, 1'b0, 3'd2, 'h010, '0);
        tick();
        idle();
        tick();
        apply_reset(2);
        repeat (4) tick();

        repeat (400) begin
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 1) != 0);
            we0 = ($urandom_range(0, 2) == 0);
            we1 = ($urandom_range(0, 2) == 0);
            funct3_0 = rand_f3();
            funct3_1 = rand_f3();
            ad = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) ad = ad & ~3;
            addr0 = ad[DM_ADDRESS-1:0];
            ad = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) ad = ad & ~3;
            addr1 = ad[DM_ADDRESS-1:0];
            wdata0 = $urandom;
            wdata1 = $urandom;
            tick();
        end
        idle();
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
